// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS-style HI/LO multiply/divide unit
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             hi_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             lo_we_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_n;
  logic [5:0]           cnt;
  logic [2*WIDTH-1:0]   work;    // mul: {acc, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     opnd;    // |multiplicand| or |divisor|
  logic                 is_div;
  logic                 neg_q;   // product / quotient sign
  logic                 neg_r;   // remainder sign (dividend sign)
  logic                 dbz;     // divide by zero: work already holds the raw result

  logic                 is_muldiv, is_div_op, signed_op, a_neg, b_neg, accept, div_zero;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, div_r, div_diff;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]     q_fix, r_fix;

  assign is_muldiv = (op_i == OP_MULT) || (op_i == OP_MULTU) || (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign is_div_op = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign a_neg     = signed_op & src1_i[WIDTH-1];
  assign b_neg     = signed_op & src2_i[WIDTH-1];
  assign abs_a     = a_neg ? -src1_i : src1_i;
  assign abs_b     = b_neg ? -src2_i : src2_i;
  assign accept    = (state == IDLE) && start_i && !flush_i && is_muldiv;
  assign div_zero  = is_div_op && (src2_i == '0);

  // Shift-add multiply step: conditionally add multiplicand into the upper half, shift right.
  assign mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, work[WIDTH-1:1]};

  // Restoring divide step: shift in next dividend bit, subtract divisor when it fits.
  assign div_r    = work[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_r >= {1'b0, opnd};
  assign div_diff = div_r - {1'b0, opnd};
  assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];
  assign div_next = {div_rem, work[WIDTH-2:0], div_ge};

  assign prod_fix = neg_q ? -work : work;
  assign q_fix    = neg_q ? -work[WIDTH-1:0] : work[WIDTH-1:0];
  assign r_fix    = neg_r ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state logic; a flush always returns to IDLE.
  always_comb begin
    state_n = state;
    if (flush_i) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_n = div_zero ? DONE : CALC;
        CALC:    if (cnt == 6'(WIDTH-1)) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Operand latch and one radix-2 step per CALC cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      work   <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dbz    <= 1'b0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (accept) begin
      cnt    <= '0;
      is_div <= is_div_op;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dbz    <= div_zero;
      if (div_zero) begin
        work <= {src1_i, {WIDTH{1'b1}}};
      end else if (is_div_op) begin
        work <= {{WIDTH{1'b0}}, abs_a};
        opnd <= abs_b;
      end else begin
        work <= {{WIDTH{1'b0}}, abs_b};
        opnd <= abs_a;
      end
    end else if (state == CALC) begin
      cnt  <= cnt + 6'd1;
      work <= is_div ? div_next : mul_next;
    end
  end

  // Outputs: stall, DONE result with sign fix, and MTHI/MTLO pass-through.
  always_comb begin
    stall_o = 1'b0;
    hi_we_o = 1'b0;
    lo_we_o = 1'b0;
    hi_o    = '0;
    lo_o    = '0;
    if (resetn && !flush_i) begin
      case (state)
        IDLE: begin
          stall_o = accept;
          if (start_i && op_i == OP_MTHI) begin
            hi_we_o = 1'b1;
            hi_o    = src1_i;
          end
          if (start_i && op_i == OP_MTLO) begin
            lo_we_o = 1'b1;
            lo_o    = src1_i;
          end
        end
        CALC: stall_o = 1'b1;
        DONE: begin
          hi_we_o = 1'b1;
          lo_we_o = 1'b1;
          if (dbz) begin
            hi_o = work[2*WIDTH-1:WIDTH];
            lo_o = work[WIDTH-1:0];
          end else if (is_div) begin
            hi_o = r_fix;
            lo_o = q_fix;
          end else begin
            hi_o = prod_fix[2*WIDTH-1:WIDTH];
            lo_o = prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
